// File: rtl/release_queue_if.sv
// ============================================================================
// release_queue_if : commit-side and release-side handshake bundle
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

interface release_queue_if #(
   parameter int TAG_W = `PHY_REG_SEL
);
   logic             commit_valid_1;
   logic             commit_valid_2;
   logic             commit_wr_1;
   logic             commit_wr_2;
   logic [TAG_W-1:0] commit_old_tag_1;
   logic [TAG_W-1:0] commit_old_tag_2;
   logic             commit_ready;
   logic [TAG_W-1:0] released_tag1;
   logic [TAG_W-1:0] released_tag2;
   logic             released_tag1_valid;
   logic             released_tag2_valid;

   // master: ROB commit / free-list side, slave: the release queue itself
   modport master (
      output commit_valid_1, commit_valid_2, commit_wr_1, commit_wr_2,
             commit_old_tag_1, commit_old_tag_2,
      input  commit_ready, released_tag1, released_tag2,
             released_tag1_valid, released_tag2_valid
   );

   modport slave (
      input  commit_valid_1, commit_valid_2, commit_wr_1, commit_wr_2,
             commit_old_tag_1, commit_old_tag_2,
      output commit_ready, released_tag1, released_tag2,
             released_tag1_valid, released_tag2_valid
   );
endinterface

`default_nettype wire

// File: rtl/release_queue.sv
// ============================================================================
// release_queue : in-order 2-in/2-out FIFO of freed physical tags for the free
// list. Optional macro RELEASE_BYPASS_EN lets pushes skip the FIFO. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

module release_queue #(
   parameter int DEPTH = 8,
   parameter int TAG_W = `PHY_REG_SEL
) (
   input  wire                      clk,
   input  wire                      reset,
   input  wire                      prmiss,
   release_queue_if.slave           rq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_nx;
   logic [PTR_W-1:0] tail_nx;

   logic             push_1;
   logic             push_2;
   logic [1:0]       push_n;
   logic [TAG_W-1:0] push_tag_a;
   logic [TAG_W-1:0] push_tag_b;
   logic [1:0]       pop_n;
   logic [1:0]       byp_n;
   logic [1:0]       rem_n;
   logic [1:0]       enq_n;
   logic [1:0]       out_n;
   logic [CNT_W:0]   space;
   logic             drop;
   logic [TAG_W-1:0] out_tag_a;
   logic [TAG_W-1:0] out_tag_b;
   logic [TAG_W-1:0] enq_tag_a;
   logic [TAG_W-1:0] enq_tag_b;

   assign rq.commit_ready = (count <= CNT_W'(DEPTH - 2));

   always_comb begin
      push_1     = rq.commit_valid_1 & rq.commit_wr_1;
      push_2     = rq.commit_valid_2 & rq.commit_wr_2;
      push_n     = {1'b0, push_1} + {1'b0, push_2};
      // Compact the requests so a lone slot-2 push takes the first position
      push_tag_a = push_1 ? rq.commit_old_tag_1 : rq.commit_old_tag_2;
      push_tag_b = rq.commit_old_tag_2;

      head_nx    = head + PTR_W'(1);
      tail_nx    = tail + PTR_W'(1);

      if (prmiss)
         pop_n = 2'd0;
      else if (count >= CNT_W'(2))
         pop_n = 2'd2;
      else
         pop_n = count[1:0];

`ifdef RELEASE_BYPASS_EN
      if (prmiss)
         byp_n = 2'd0;
      else if ((2'd2 - pop_n) < push_n)
         byp_n = 2'd2 - pop_n;
      else
         byp_n = push_n;
`else
      byp_n = 2'd0;
`endif

      rem_n = push_n - byp_n;

      // Entries popped this edge free their slots for this edge's writes
      space = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(pop_n);
      drop  = (space < (CNT_W+1)'(rem_n));
      enq_n = drop ? space[1:0] : rem_n;

      out_n = pop_n + byp_n;

      out_tag_a = (pop_n != 2'd0) ? mem[head] : push_tag_a;
      if (pop_n == 2'd2)
         out_tag_b = mem[head_nx];
      else if (pop_n == 2'd1)
         out_tag_b = push_tag_a;
      else
         out_tag_b = push_tag_b;

      enq_tag_a = (byp_n == 2'd0) ? push_tag_a : push_tag_b;
      enq_tag_b = push_tag_b;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head                   <= '0;
         tail                   <= '0;
         count                  <= '0;
         overflow               <= 1'b0;
         rq.released_tag1       <= '0;
         rq.released_tag2       <= '0;
         rq.released_tag1_valid <= 1'b0;
         rq.released_tag2_valid <= 1'b0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(enq_n);
         count <= count + CNT_W'(enq_n) - CNT_W'(pop_n);
         if (drop)
            overflow <= 1'b1;

         // Tag values hold whenever their slot carries nothing new
         rq.released_tag1_valid <= (out_n != 2'd0);
         rq.released_tag2_valid <= (out_n == 2'd2);
         if (out_n != 2'd0)
            rq.released_tag1 <= out_tag_a;
         if (out_n == 2'd2)
            rq.released_tag2 <= out_tag_b;
      end
   end

   // Storage needs no reset: occupancy is tracked entirely by count/pointers
   always_ff @(posedge clk) begin
      if (enq_n != 2'd0)
         mem[tail] <= enq_tag_a;
      if (enq_n == 2'd2)
         mem[tail_nx] <= enq_tag_b;
   end

endmodule

`default_nettype wire

// File: tb/tb_release_queue.sv
// ============================================================================
// tb_release_queue : directed stimulus with a scoreboard of released tags
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_release_queue;
   localparam int DEPTH = 8;
   localparam int TAG_W = 6;
   localparam int CNT_W = 4;

   logic             clk    = 1'b0;
   logic             reset  = 1'b0;
   logic             prmiss = 1'b0;
   logic [CNT_W-1:0] count;
   logic             overflow;

   release_queue_if #(.TAG_W(TAG_W)) rq ();

   release_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .prmiss   (prmiss),
      .rq       (rq),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [TAG_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rq.commit_valid_1   = 1'b0;
      rq.commit_valid_2   = 1'b0;
      rq.commit_wr_1      = 1'b0;
      rq.commit_wr_2      = 1'b0;
      rq.commit_old_tag_1 = '0;
      rq.commit_old_tag_2 = '0;
   endtask

   task automatic push_pair(input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
      rq.commit_valid_1   = 1'b1;
      rq.commit_wr_1      = 1'b1;
      rq.commit_old_tag_1 = t1;
      rq.commit_valid_2   = 1'b1;
      rq.commit_wr_2      = 1'b1;
      rq.commit_old_tag_2 = t2;
      exp_q.push_back(t1);
      exp_q.push_back(t2);
   endtask

   task automatic push_one(input logic [TAG_W-1:0] t1);
      idle();
      rq.commit_valid_1   = 1'b1;
      rq.commit_wr_1      = 1'b1;
      rq.commit_old_tag_1 = t1;
      exp_q.push_back(t1);
   endtask

   // Monitor: every valid output slot must match the next expected tag
   always @(negedge clk) begin
      if (reset) begin
         chk("valid_order", rq.released_tag2_valid & ~rq.released_tag1_valid, 0);
         if (rq.released_tag1_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_tag1: got %0d expected none", rq.released_tag1);
            end else
               chk("sb_tag1", rq.released_tag1, exp_q.pop_front());
         end
         if (rq.released_tag2_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_tag2: got %0d expected none", rq.released_tag2);
            end else
               chk("sb_tag2", rq.released_tag2, exp_q.pop_front());
         end
      end
   end

   initial begin
      idle();
      repeat (2) step();
      chk("rst_count", count, 0);
      chk("rst_v1", rq.released_tag1_valid, 0);
      chk("rst_v2", rq.released_tag2_valid, 0);
      chk("rst_tag1", rq.released_tag1, 0);
      chk("rst_tag2", rq.released_tag2, 0);
      chk("rst_ready", rq.commit_ready, 1);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      step();

      // Pair push latency
      push_pair(6'd3, 6'd7);
      step();
      idle();
`ifndef RELEASE_BYPASS_EN
      chk("pair_wait_count", count, 2);
      chk("pair_wait_v1", rq.released_tag1_valid, 0);
      step();
`endif
      chk("pair_v1", rq.released_tag1_valid, 1);
      chk("pair_v2", rq.released_tag2_valid, 1);
      chk("pair_tag1", rq.released_tag1, 3);
      chk("pair_tag2", rq.released_tag2, 7);
      chk("pair_count", count, 0);
      step();

      // Lone slot-2 push; slot 1 retires without a register write
      rq.commit_valid_1   = 1'b1;
      rq.commit_wr_1      = 1'b0;
      rq.commit_old_tag_1 = 6'd5;
      rq.commit_valid_2   = 1'b1;
      rq.commit_wr_2      = 1'b1;
      rq.commit_old_tag_2 = 6'd9;
      exp_q.push_back(6'd9);
      step();
      idle();
`ifndef RELEASE_BYPASS_EN
      step();
`endif
      chk("lone_v1", rq.released_tag1_valid, 1);
      chk("lone_tag1", rq.released_tag1, 9);
      chk("lone_v2", rq.released_tag2_valid, 0);
      step();

      // Fill to DEPTH under prmiss, then drain two per cycle
      prmiss = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fill_ready", rq.commit_ready, 1);
         push_pair(6'(10 + 2*i), 6'(11 + 2*i));
         step();
         chk("fill_v1", rq.released_tag1_valid, 0);
      end
      idle();
      chk("full_count", count, 8);
      chk("full_ready", rq.commit_ready, 0);
      step();
      chk("full_hold_v1", rq.released_tag1_valid, 0);
      chk("full_hold_v2", rq.released_tag2_valid, 0);
      prmiss = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_v1", rq.released_tag1_valid, 1);
         chk("drain_v2", rq.released_tag2_valid, 1);
         chk("drain_count", count, 6 - 2*i);
      end
      step();
      chk("drained_v1", rq.released_tag1_valid, 0);
      chk("drained_count", count, 0);

      // Overflow: count 7, push two, only the first fits
      prmiss = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_pair(6'(20 + 2*i), 6'(21 + 2*i));
         step();
      end
      push_one(6'd26);
      step();
      idle();
      chk("ovf_pre_count", count, 7);
      chk("ovf_pre_ready", rq.commit_ready, 0);
      chk("ovf_pre_flag", overflow, 0);
      rq.commit_valid_1   = 1'b1;
      rq.commit_wr_1      = 1'b1;
      rq.commit_old_tag_1 = 6'd27;
      rq.commit_valid_2   = 1'b1;
      rq.commit_wr_2      = 1'b1;
      rq.commit_old_tag_2 = 6'd28;
      exp_q.push_back(6'd27);
      step();
      idle();
      chk("ovf_count", count, 8);
      chk("ovf_flag", overflow, 1);
      prmiss = 1'b0;
      repeat (5) step();
      chk("ovf_drained_count", count, 0);
      chk("ovf_sticky", overflow, 1);

      // Asynchronous reset mid-stream with count 5 and valid outputs
      prmiss = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_pair(6'(30 + 2*i), 6'(31 + 2*i));
         step();
      end
      push_one(6'd36);
      step();
      idle();
      prmiss = 1'b0;
      step();
      chk("mid_count", count, 5);
      chk("mid_v1", rq.released_tag1_valid, 1);
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk("async_count", count, 0);
      chk("async_v1", rq.released_tag1_valid, 0);
      chk("async_v2", rq.released_tag2_valid, 0);
      chk("async_ready", rq.commit_ready, 1);
      chk("async_overflow", overflow, 0);
      step();
      reset = 1'b1;
      step();

      // Steady push/pop across pointer wrap-around
      for (int i = 0; i < 20; i++) begin
         push_pair(6'(2*i + 1), 6'(2*i + 2));
         step();
         chk("wrap_count_le2", count <= 4'd2, 1);
      end
      idle();
      repeat (3) step();
      chk("wrap_final_count", count, 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
